// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt controller slice.
package irq_pkg;

   localparam int NUM_IRQ = 8;
   localparam int ID_W    = $clog2(NUM_IRQ);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } irq_state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational priority encoder: the highest set index of req wins.
module irq_prio_sel
   import irq_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               any_valid
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output; without them a zero input would infer a latch.
      id        = '0;
      any_valid = 1'b0;
      // Ascending scan: a later (higher) set bit overwrites an earlier one.
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (req[i]) begin
            id        = ID_W'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: captures requests into pending, masks them, presents the
// highest eligible one with a valid/ack handshake and tracks it until EOI.
module irq_controller
   import irq_pkg::*;
#(
   parameter int                 EDGE_MODE = 1,
   parameter logic [NUM_IRQ-1:0] MASK_RST  = 8'h00
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               int_en,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               irq_ack,
   input  logic               eoi,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] in_service,
   output logic [NUM_IRQ-1:0] mask,
   output logic               busy
);

   irq_state_t         state, state_next;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] set_vec, clr_vec, eligible, id_onehot;
   logic [NUM_IRQ-1:0] pending_next, in_service_next;
   logic [ID_W-1:0]    sel_id, irq_id_next;
   logic               sel_valid, withdraw;

   assign set_vec   = (EDGE_MODE != 0) ? (irq_in & ~irq_prev) : irq_in;
   assign eligible  = pending & ~mask;
   assign withdraw  = ~int_en | mask[irq_id];
   assign id_onehot = NUM_IRQ'(1) << irq_id;
   assign busy      = (state != IDLE);

   irq_prio_sel u_prio_sel (
      .req       (eligible),
      .id        (sel_id),
      .any_valid (sel_valid)
   );

   always_comb begin
      state_next      = state;
      irq_id_next     = irq_id;
      clr_vec         = '0;
      in_service_next = in_service;
      unique case (state)
         IDLE: begin
            if (int_en && sel_valid) begin
               state_next  = REQ;
               irq_id_next = sel_id;
            end
         end
         REQ: begin
            // Withdraw outranks a same-cycle ack; the request stays pending.
            if (withdraw) begin
               state_next = IDLE;
            end else if (irq_ack) begin
               clr_vec         = id_onehot;
               in_service_next = id_onehot;
               state_next      = SERVICE;
            end
         end
         SERVICE: begin
            if (eoi) begin
               in_service_next = '0;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // A capture in the ack cycle re-sets the bit being cleared.
      pending_next = (pending & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the clocked branch.
      if (!rstN) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rstN) begin
         irq_prev   <= '0;
         pending    <= '0;
         in_service <= '0;
         mask       <= MASK_RST;
         irq_valid  <= 1'b0;
         irq_id     <= '0;
      end else begin
         irq_prev   <= irq_in;
         pending    <= pending_next;
         in_service <= in_service_next;
         irq_valid  <= (state_next == REQ);
         irq_id     <= irq_id_next;
         if (mask_wr) begin
            mask <= mask_wdata;
         end
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: an edge-mode and a level-mode instance share stimulus
// and are both compared each cycle against a behavioural model.
module tb_irq_controller;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] irq_in;
   logic       int_en;
   logic       mask_wr;
   logic [7:0] mask_wdata;
   logic       irq_ack;
   logic       eoi;

   logic       e_valid, l_valid, e_busy, l_busy;
   logic [2:0] e_id, l_id;
   logic [7:0] e_pend, l_pend, e_insvc, l_insvc, e_mask, l_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_controller #(.EDGE_MODE(1), .MASK_RST(8'h00)) dut (
      .clk(clk), .rstN(rstN), .irq_in(irq_in), .int_en(int_en),
      .mask_wr(mask_wr), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
      .irq_valid(e_valid), .irq_id(e_id), .pending(e_pend),
      .in_service(e_insvc), .mask(e_mask), .busy(e_busy)
   );

   irq_controller #(.EDGE_MODE(0), .MASK_RST(8'h01)) dut_lvl (
      .clk(clk), .rstN(rstN), .irq_in(irq_in), .int_en(int_en),
      .mask_wr(mask_wr), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
      .irq_valid(l_valid), .irq_id(l_id), .pending(l_pend),
      .in_service(l_insvc), .mask(l_mask), .busy(l_busy)
   );

   // Behavioural model, index 0 = edge instance, 1 = level instance.
   localparam int P_IDLE    = 0;
   localparam int P_PRESENT = 1;
   localparam int P_SERVE   = 2;

   int         m_phase [2];
   int         m_id    [2];
   logic [7:0] m_pend  [2];
   logic [7:0] m_insvc [2];
   logic [7:0] m_mask  [2];
   logic [7:0] m_prev  [2];

   function automatic int highest(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (!rstN) begin
            m_phase[k] = P_IDLE;
            m_id[k]    = 0;
            m_pend[k]  = 8'h00;
            m_insvc[k] = 8'h00;
            m_mask[k]  = (k == 0) ? 8'h00 : 8'h01;
            m_prev[k]  = 8'h00;
         end else begin
            logic [7:0] newreq;
            logic [7:0] served;
            int         top;
            newreq = (k == 0) ? (irq_in & ~m_prev[k]) : irq_in;
            served = 8'h00;
            top    = highest(m_pend[k] & ~m_mask[k]);
            if (m_phase[k] == P_IDLE) begin
               if (int_en && top >= 0) begin
                  m_id[k]    = top;
                  m_phase[k] = P_PRESENT;
               end
            end else if (m_phase[k] == P_PRESENT) begin
               if (!int_en || m_mask[k][m_id[k]]) begin
                  m_phase[k] = P_IDLE;
               end else if (irq_ack) begin
                  served[m_id[k]] = 1'b1;
                  m_insvc[k]      = served;
                  m_phase[k]      = P_SERVE;
               end
            end else if (eoi) begin
               m_insvc[k] = 8'h00;
               m_phase[k] = P_IDLE;
            end
            m_pend[k] = (m_pend[k] & ~served) | newreq;
            m_prev[k] = irq_in;
            if (mask_wr) m_mask[k] = mask_wdata;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_inst(input string tag, input int k, input logic v, input logic [2:0] id,
                             input logic [7:0] p, input logic [7:0] s, input logic [7:0] mk,
                             input logic b);
      check({tag, ".valid"},   32'(v),  32'(m_phase[k] == P_PRESENT));
      check({tag, ".id"},      32'(id), 32'(m_id[k]));
      check({tag, ".pending"}, 32'(p),  32'(m_pend[k]));
      check({tag, ".in_svc"},  32'(s),  32'(m_insvc[k]));
      check({tag, ".mask"},    32'(mk), 32'(m_mask[k]));
      check({tag, ".busy"},    32'(b),  32'(m_phase[k] != P_IDLE));
   endtask

   // One clock: DUTs and model sample the same inputs, then compare away from the edge.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_inst("edge", 0, e_valid, e_id, e_pend, e_insvc, e_mask, e_busy);
      check_inst("lvl",  1, l_valid, l_id, l_pend, l_insvc, l_mask, l_busy);
   endtask

   task automatic idle_inputs();
      irq_in     = 8'h00;
      mask_wr    = 1'b0;
      mask_wdata = 8'h00;
      irq_ack    = 1'b0;
      eoi        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstN = 1'b0;
      step();
      step();
      rstN   = 1'b1;
      int_en = 1'b1;
   endtask

   typedef struct {
      logic       rst_n;
      logic [7:0] irq;
      logic       en, ack, eo;
      logic       valid;
      logic [2:0] id;
      logic [7:0] pend, insvc;
      logic       busy;
   } vec_t;

   vec_t tbl [16];

   initial begin
      // rst, irq, en, ack, eoi | valid, id, pending, in_service, busy (edge instance)
      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h04, 8'h00, 1'b0};
      tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h00, 1'b1};
      tbl[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 1'b1};
      tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 1'b1};
      tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00, 1'b0};
      tbl[8]  = '{1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h81, 8'h00, 1'b0};
      tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'h81, 8'h00, 1'b1};
      tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 8'h01, 8'h80, 1'b1};
      tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h01, 8'h00, 1'b0};
      tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00, 1'b1};
      tbl[13] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h01, 1'b1};
      tbl[14] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[15] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};

      rstN   = 1'b0;
      int_en = 1'b0;
      idle_inputs();

      // Reset, single request, then priority 7 before 0, ack/eoi ignored when idle.
      for (int i = 0; i < 16; i++) begin
         rstN    = tbl[i].rst_n;
         irq_in  = tbl[i].irq;
         int_en  = tbl[i].en;
         irq_ack = tbl[i].ack;
         eoi     = tbl[i].eo;
         step();
         check($sformatf("tbl%0d.valid", i),   32'(e_valid), 32'(tbl[i].valid));
         check($sformatf("tbl%0d.id", i),      32'(e_id),    32'(tbl[i].id));
         check($sformatf("tbl%0d.pending", i), 32'(e_pend),  32'(tbl[i].pend));
         check($sformatf("tbl%0d.in_svc", i),  32'(e_insvc), 32'(tbl[i].insvc));
         check($sformatf("tbl%0d.busy", i),    32'(e_busy),  32'(tbl[i].busy));
      end

      // Masking hides a request; unmasking presents it; masking during REQ withdraws.
      do_reset();
      mask_wr = 1'b1; mask_wdata = 8'h80; step();
      mask_wr = 1'b0; irq_in = 8'h80; step();
      irq_in = 8'h00; step(); step();
      check("mask_hide.valid", 32'(e_valid), 0);
      check("mask_hide.pending", 32'(e_pend), 'h80);
      mask_wr = 1'b1; mask_wdata = 8'h00; step();
      mask_wr = 1'b0; step();
      check("unmask.valid", 32'(e_valid), 1);
      check("unmask.id", 32'(e_id), 7);
      mask_wr = 1'b1; mask_wdata = 8'h80; step();
      mask_wr = 1'b0; step();
      check("withdraw_mask.valid", 32'(e_valid), 0);
      check("withdraw_mask.pending", 32'(e_pend), 'h80);
      check("withdraw_mask.busy", 32'(e_busy), 0);

      // int_en gating, then withdraw outranking a same-cycle ack.
      do_reset();
      int_en = 1'b0; irq_in = 8'h10; step();
      irq_in = 8'h00; step(); step(); step();
      check("int_en_off.busy", 32'(e_busy), 0);
      check("int_en_off.pending", 32'(e_pend), 'h10);
      int_en = 1'b1; step();
      check("int_en_on.valid", 32'(e_valid), 1);
      check("int_en_on.id", 32'(e_id), 4);
      int_en = 1'b0; irq_ack = 1'b1; step();
      irq_ack = 1'b0;
      check("withdraw_ack.valid", 32'(e_valid), 0);
      check("withdraw_ack.in_svc", 32'(e_insvc), 0);
      check("withdraw_ack.pending", 32'(e_pend), 'h10);

      // Held request across ack: edge mode clears, level mode re-sets.
      do_reset();
      irq_in = 8'h08; step(); step();
      check("hold.edge_valid", 32'(e_valid), 1);
      check("hold.lvl_valid", 32'(l_valid), 1);
      irq_ack = 1'b1; step();
      irq_ack = 1'b0;
      check("hold_ack.edge_pending", 32'(e_pend), 0);
      check("hold_ack.lvl_pending", 32'(l_pend), 'h08);
      check("hold_ack.edge_in_svc", 32'(e_insvc), 'h08);
      step();
      check("hold_after.edge_pending", 32'(e_pend), 0);
      check("hold_after.lvl_pending", 32'(l_pend), 'h08);
      irq_in = 8'h00; eoi = 1'b1; step();
      eoi = 1'b0;

      // Fresh edge on the acked bit in the ack cycle: set wins over clear.
      do_reset();
      irq_in = 8'h08; step();
      irq_in = 8'h00; step();
      irq_ack = 1'b1; irq_in = 8'h08; step();
      irq_ack = 1'b0; irq_in = 8'h00;
      check("set_over_clr.pending", 32'(e_pend), 'h08);
      check("set_over_clr.in_svc", 32'(e_insvc), 'h08);

      // Reset in SERVICE with pending 8'h22 and a non-default mask.
      do_reset();
      mask_wr = 1'b1; mask_wdata = 8'h40; irq_in = 8'h22; step();
      mask_wr = 1'b0; irq_in = 8'h00; step();
      irq_ack = 1'b1; step();
      irq_ack = 1'b0; irq_in = 8'h20; step();
      irq_in = 8'h00;
      check("pre_rst.pending", 32'(e_pend), 'h22);
      check("pre_rst.busy", 32'(e_busy), 1);
      rstN = 1'b0; step();
      check("mid_rst.pending", 32'(e_pend), 0);
      check("mid_rst.in_svc", 32'(e_insvc), 0);
      check("mid_rst.mask", 32'(e_mask), 0);
      check("mid_rst.lvl_mask", 32'(l_mask), 'h01);
      check("mid_rst.busy", 32'(e_busy), 0);
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst.valid", 32'(e_valid), 0);
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rstN       = ($urandom_range(63) != 0);
         irq_in     = 8'($urandom & $urandom & $urandom);
         int_en     = ($urandom_range(7) != 0);
         mask_wr    = ($urandom_range(15) == 0);
         mask_wdata = 8'($urandom & $urandom);
         irq_ack    = ($urandom_range(2) == 0);
         eoi        = ($urandom_range(3) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
